// File: rtl/bit_counter_iter.sv
// bit_counter_iter
//   Counts bits of a DATA_W-bit word, CHUNK_W bits per clock. It is the
//   parametrised successor of the fixed 32-bit demo counter and feeds the
//   7-segment decoder.
//   Count modes: 00 ones, 01 zeros, 10 leading zeros, 11 trailing zeros.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   Valid    request; DataIn and Mode are sampled on accept (IDLE or DONE)
//   DataIn   operand word
//   Mode     count mode
//   Ready    result valid; held until the next accept or reset
//   Busy     high while the word is being scanned (RUN)
//   DataOut  zero-extended count, stable outside the RUN->DONE update
module bit_counter_iter #(
  parameter  int DATA_W  = 32,
  parameter  int CHUNK_W = 4,
  localparam int OUT_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Valid,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [1:0]        Mode,
  output logic              Ready,
  output logic              Busy,
  output logic [OUT_W-1:0]  DataOut
);

  localparam int N     = DATA_W / CHUNK_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] MODE_ONES  = 2'b00;
  localparam logic [1:0] MODE_ZEROS = 2'b01;
  localparam logic [1:0] MODE_TZ    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [DATA_W-1:0]   shift_reg;
  logic [OUT_W-1:0]    acc;
  logic [CNT_W-1:0]    chunk_cnt;
  logic                stop;
  logic [1:0]          mode_q;
  logic [OUT_W-1:0]    data_out_q;

  logic                accept;
  logic                last_chunk;
  logic [DATA_W-1:0]   data_rev;
  logic [CHUNK_W-1:0]  chunk;
  logic [OUT_W-1:0]    ones_cnt;
  logic [OUT_W-1:0]    zeros_cnt;
  logic [OUT_W-1:0]    lead_cnt;
  logic                chunk_has_one;
  logic [OUT_W-1:0]    acc_next;
  logic                stop_next;

  assign accept     = Valid && (state == IDLE || state == DONE);
  assign last_chunk = (chunk_cnt == CNT_W'(N - 1));
  assign chunk      = shift_reg[DATA_W-1 -: CHUNK_W];

  // Trailing-zero mode reverses the word on accept so every mode scans
  // from the MSB end with the same leading-zero logic.
  always_comb begin
    data_rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data_rev[i] = DataIn[DATA_W-1-i];
    end
  end

  // Per-chunk statistics: popcount and zeros above the first 1 (MSB first).
  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned, which is what would infer a latch.
  always_comb begin
    ones_cnt      = '0;
    lead_cnt      = '0;
    chunk_has_one = 1'b0;
    for (int i = 0; i < CHUNK_W; i++) begin
      ones_cnt = ones_cnt + OUT_W'(chunk[i]);
    end
    for (int i = CHUNK_W - 1; i >= 0; i--) begin
      if (!chunk_has_one) begin
        if (chunk[i]) chunk_has_one = 1'b1;
        else          lead_cnt      = lead_cnt + OUT_W'(1);
      end
    end
    zeros_cnt = OUT_W'(CHUNK_W) - ones_cnt;
  end

  // Accumulator update for one RUN cycle. Once the first 1 has been seen
  // in a leading/trailing-zero scan, the remaining chunks contribute 0.
  always_comb begin
    acc_next  = acc;
    stop_next = stop;
    case (mode_q)
      MODE_ONES:  acc_next = acc + ones_cnt;
      MODE_ZEROS: acc_next = acc + zeros_cnt;
      default: begin
        if (!stop) begin
          acc_next  = acc + lead_cnt;
          stop_next = chunk_has_one;
        end
      end
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Valid during RUN is ignored; there is no early exit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (accept) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    Ready = 1'b0;
    Busy  = 1'b0;
    case (state)
      RUN:     Busy  = 1'b1;
      DONE:    Ready = 1'b1;
      default: ;
    endcase
  end

  // Datapath. The shift register is an ordinary register, not a memory,
  // so it is cleared on reset along with the rest of the context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      acc        <= '0;
      chunk_cnt  <= '0;
      stop       <= 1'b0;
      mode_q     <= MODE_ONES;
      data_out_q <= '0;
    end else if (accept) begin
      shift_reg <= (Mode == MODE_TZ) ? data_rev : DataIn;
      mode_q    <= Mode;
      acc       <= '0;
      chunk_cnt <= '0;
      stop      <= 1'b0;
    end else if (state == RUN) begin
      shift_reg <= shift_reg << CHUNK_W;
      acc       <= acc_next;
      stop      <= stop_next;
      chunk_cnt <= chunk_cnt + CNT_W'(1);
      // DataOut only moves on the RUN->DONE transition.
      if (last_chunk) data_out_q <= acc_next;
    end
  end

  assign DataOut = data_out_q;

endmodule

// File: tb/tb_bit_counter_iter.sv
// Testbench for bit_counter_iter (DATA_W=32, CHUNK_W=4).
// A driver issues requests and pushes the expected count plus the accept
// cycle into a queue; a monitor pops on every rising Ready and compares
// both the count and the latency. Expected counts come from a whole-word
// reference model.
module tb_bit_counter_iter;

  localparam int DATA_W  = 32;
  localparam int CHUNK_W = 4;
  localparam int OUT_W   = $clog2(DATA_W + 1);
  localparam int N       = DATA_W / CHUNK_W;

  logic              clk;
  logic              rst_n;
  logic              Valid;
  logic [DATA_W-1:0] DataIn;
  logic [1:0]        Mode;
  logic              Ready;
  logic              Busy;
  logic [OUT_W-1:0]  DataOut;

  typedef struct {
    int exp;
    int cyc;
  } item_t;

  item_t q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;

  bit_counter_iter #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Valid   (Valid),
    .DataIn  (DataIn),
    .Mode    (Mode),
    .Ready   (Ready),
    .Busy    (Busy),
    .DataOut (DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: counts straight from the definition of each mode.
  function automatic int model(input logic [1:0] m, input logic [31:0] d);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    case (m)
      2'b00: n = $countones(d);
      2'b01: n = DATA_W - $countones(d);
      2'b10: for (int i = DATA_W - 1; i >= 0; i--) begin
               if (d[i]) found = 1'b1;
               if (!found) n++;
             end
      default: for (int i = 0; i < DATA_W; i++) begin
               if (d[i]) found = 1'b1;
               if (!found) n++;
             end
    endcase
    return n;
  endfunction

  // Issue one request; returns at the falling edge after the accept edge.
  task automatic send(input logic [1:0] m, input logic [31:0] d);
    int guard;
    item_t it;
    guard = 0;
    @(negedge clk);
    while (Busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_wait: Busy still %0b after %0d cycles, required 0", Busy, guard);
    end
    Valid  = 1'b1;
    Mode   = m;
    DataIn = d;
    @(negedge clk);
    Valid  = 1'b0;
    it.exp = model(m, d);
    it.cyc = cyc;
    q.push_back(it);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: compares on every rising Ready and checks DataOut never moves
  // except when a new result appears.
  initial begin : monitor
    logic             rdy_q;
    logic             rst_q;
    logic [OUT_W-1:0] out_q;
    item_t            it;
    rdy_q = 1'b0;
    rst_q = 1'b0;
    out_q = '0;
    forever begin
      @(negedge clk);
      if (rst_n && Ready && !rdy_q) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: Ready=1 with DataOut=%0d, required no result", DataOut);
        end else begin
          it = q.pop_front();
          check("dataout", 32'(DataOut), 32'(it.exp));
          check("latency", 32'(cyc - it.cyc), 32'(N));
        end
      end else if (rst_n && rst_q) begin
        check("dataout_stable", 32'(DataOut), 32'(out_q));
      end
      rdy_q = Ready;
      rst_q = rst_n;
      out_q = DataOut;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] d;
    logic [1:0]  m;
    Valid  = 1'b0;
    DataIn = '0;
    Mode   = 2'b00;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_ready", 32'(Ready), 0);
    check("reset_busy", 32'(Busy), 0);
    check("reset_dataout", 32'(DataOut), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single-pulse request, Busy for N cycles, Ready held while idle.
    send(2'b00, 32'hFFC0_0000);
    for (int i = 0; i < N; i++) begin
      check("t1_busy", 32'(Busy), 1);
      check("t1_ready_low", 32'(Ready), 0);
      @(negedge clk);
    end
    check("t1_busy_done", 32'(Busy), 0);
    check("t1_ready", 32'(Ready), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t1_ready_hold", 32'(Ready), 1);
      check("t1_value_hold", 32'(DataOut), 10);
    end

    // 2-4: directed patterns, including mid-chunk first one.
    send(2'b01, 32'h0000_000F); wait_idle();
    send(2'b00, 32'hFFFF_FFFF); wait_idle();
    send(2'b01, 32'hFFFF_FFFF); wait_idle();
    send(2'b10, 32'h0001_0000); wait_idle();
    send(2'b10, 32'h8000_0000); wait_idle();
    send(2'b10, 32'h0000_0000); wait_idle();
    send(2'b11, 32'h0001_0000); wait_idle();
    send(2'b11, 32'h0000_0001); wait_idle();
    send(2'b11, 32'h0000_0000); wait_idle();
    send(2'b10, 32'hFFFF_FFFF); wait_idle();
    send(2'b11, 32'hFFFF_FFFF); wait_idle();

    // 5: Valid during RUN is ignored; Valid in DONE restarts immediately.
    send(2'b00, 32'h0000_00FF);
    @(negedge clk);
    Valid  = 1'b1;
    Mode   = 2'b00;
    DataIn = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
    Valid = 1'b0;
    wait_idle();
    send(2'b00, 32'h0F0F_0F0F);
    check("t5_ready_drop", 32'(Ready), 0);
    check("t5_busy", 32'(Busy), 1);
    wait_idle();

    // 6: reset in the middle of RUN aborts with no result.
    send(2'b00, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_ready", 32'(Ready), 0);
    check("t6_busy", 32'(Busy), 0);
    check("t6_dataout", 32'(DataOut), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_idle_ready", 32'(Ready), 0);
      check("t6_idle_busy", 32'(Busy), 0);
    end
    send(2'b00, 32'h0000_0001);
    wait_idle();

    // Randomized requests with a mix of gaps and back-to-back issue.
    for (int i = 0; i < 60; i++) begin
      m = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = $urandom >> $urandom_range(0, 31);
        2: d = $urandom << $urandom_range(0, 31);
        default: d = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      endcase
      send(m, d);
      if ($urandom_range(0, 2) != 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
